// File: rtl/zbt_point_writer_if.sv
// Bundle between zbt_point_writer and its neighbours: the point lookup
// (index/value), the memory arbiter (allowed), the zbt_6111 wrapper
// (mem_addr/mem_we/mem_write_data) and the run controller (start/busy/done).
//   master : the writer itself
//   slave  : the surrounding system (lookup, arbiter, wrapper, controller)
// With ZBT_WR_VERIFY_EN defined, mem_read_data (wrapper -> writer) and the
// sticky error flag (writer -> system) are added.
interface zbt_point_writer_if #(
  parameter int unsigned INDEX_W = 2
);
  logic               start;
  logic               allowed;
  logic [INDEX_W-1:0] index;
  logic [35:0]        value;
  logic [18:0]        mem_addr;
  logic               mem_we;
  logic [35:0]        mem_write_data;
  logic               busy;
  logic               done;
`ifdef ZBT_WR_VERIFY_EN
  logic [35:0]        mem_read_data;
  logic               error;

  modport master (
    input  start, allowed, value, mem_read_data,
    output index, mem_addr, mem_we, mem_write_data, busy, done, error
  );
  modport slave (
    output start, allowed, value, mem_read_data,
    input  index, mem_addr, mem_we, mem_write_data, busy, done, error
  );
`else
  modport master (
    input  start, allowed, value,
    output index, mem_addr, mem_we, mem_write_data, busy, done
  );
  modport slave (
    output start, allowed, value,
    input  index, mem_addr, mem_we, mem_write_data, busy, done
  );
`endif
endinterface

// File: rtl/zbt_point_writer.sv
// zbt_point_writer: walks the point lookup from index 0 to NUM_POINTS-1 and
// writes each returned 36-bit record (x in [17:8], y in [7:0]) to ZBT SRAM at
// BASE_ADDR+index, issuing a write only in cycles where the arbiter grants
// access (allowed=1). addr/we/data are registered and presented together; the
// zbt_6111 wrapper absorbs the ZBT data-pipeline delay.
// Ports:
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : zbt_point_writer_if.master (start, allowed, index, value,
//                mem_addr, mem_we, mem_write_data, busy, done
//                [+ mem_read_data, error])
// Optional feature macro: ZBT_WR_VERIFY_EN -- after the writes, reads every
// record back (data returns 2 cycles after the address) and raises a sticky
// error flag on any mismatch.
module zbt_point_writer #(
  parameter int unsigned NUM_POINTS = 4,
  parameter int unsigned INDEX_W    = 2,
  parameter logic [18:0] BASE_ADDR  = 19'h00000
) (
  input logic              clk,
  input logic              reset,
  zbt_point_writer_if.master bus
);

`ifdef ZBT_WR_VERIFY_EN
  typedef enum logic [2:0] {IDLE, WRITE, VERIFY, DRAIN, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
`endif

  state_t             state, state_n;
  logic [INDEX_W-1:0] counter;
  logic               last;
  logic               issue_wr;
  logic               issue_rd;

  logic [18:0]        mem_addr_r;
  logic               mem_we_r;
  logic [35:0]        mem_wdata_r;
  logic               busy_r;
  logic               done_r;

`ifdef ZBT_WR_VERIFY_EN
  // exp0 lines up with the read address on the bus; exp2 with the returned data
  logic               v0, v1, v2;
  logic [35:0]        exp0, exp1, exp2;
  logic               error_r;
`endif

  assign last = (counter == INDEX_W'(NUM_POINTS - 1));

  always_comb begin
    state_n  = state;
    issue_wr = 1'b0;
    issue_rd = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_n = WRITE;
      end
      WRITE: begin
        if (bus.allowed) begin
          issue_wr = 1'b1;
`ifdef ZBT_WR_VERIFY_EN
          if (last) state_n = VERIFY;
`else
          if (last) state_n = DONE;
`endif
        end
      end
`ifdef ZBT_WR_VERIFY_EN
      VERIFY: begin
        if (bus.allowed) begin
          issue_rd = 1'b1;
          if (last) state_n = DRAIN;
        end
      end
      DRAIN: begin
        // no reads issue here, so v1 without v0 means the final read is one
        // cycle from its compare; DONE then lines up with that compare
        if (v1 && !v0) state_n = DONE;
      end
`endif
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      counter     <= '0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= BASE_ADDR;
      mem_wdata_r <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
`ifdef ZBT_WR_VERIFY_EN
      v0      <= 1'b0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      exp0    <= '0;
      exp1    <= '0;
      exp2    <= '0;
      error_r <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      mem_we_r <= issue_wr;
      done_r   <= (state == DONE);
      if (issue_wr || issue_rd) begin
        mem_addr_r <= BASE_ADDR + 19'(counter);
        counter    <= last ? '0 : counter + 1'b1;
      end
      if (issue_wr) mem_wdata_r <= bus.value;
      if (state == IDLE && bus.start) busy_r <= 1'b1;
      else if (state == DONE)         busy_r <= 1'b0;
`ifdef ZBT_WR_VERIFY_EN
      v0 <= issue_rd;
      if (issue_rd) exp0 <= bus.value;
      v1   <= v0;
      exp1 <= exp0;
      v2   <= v1;
      exp2 <= exp1;
      if (state == IDLE && bus.start)              error_r <= 1'b0;
      else if (v2 && (bus.mem_read_data != exp2)) error_r <= 1'b1;
`endif
    end
  end

`ifdef ZBT_WR_VERIFY_EN
  assign bus.index = (state == WRITE || state == VERIFY) ? counter : '0;
  assign bus.error = error_r;
`else
  assign bus.index = (state == WRITE) ? counter : '0;
`endif
  assign bus.mem_addr       = mem_addr_r;
  assign bus.mem_we         = mem_we_r;
  assign bus.mem_write_data = mem_wdata_r;
  assign bus.busy           = busy_r;
  assign bus.done           = done_r;

endmodule

// File: tb/tb_zbt_point_writer.sv
module tb_zbt_point_writer;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic allowed;
  logic allowed_prev = 1'b0;
  logic corrupt = 1'b0;
  int   cyc = 0;

  int vectors = 0;
  int errors  = 0;
  int runs    = 0;
  int done_cnt0 = 0;
  int done_cyc0 = 0;
  int last_we_cyc0 = 0;

  typedef struct packed {
    logic [18:0] addr;
    logic [35:0] data;
  } wr_t;

  wr_t q0[$];
  wr_t q1[$];

  zbt_point_writer_if #(.INDEX_W(2)) if0 ();
  zbt_point_writer_if #(.INDEX_W(2)) if1 ();

  zbt_point_writer #(.NUM_POINTS(4), .INDEX_W(2), .BASE_ADDR(19'h00000)) dut0 (
    .clk(clk), .reset(reset), .bus(if0.master)
  );
  zbt_point_writer #(.NUM_POINTS(4), .INDEX_W(2), .BASE_ADDR(19'h7FFFE)) dut1 (
    .clk(clk), .reset(reset), .bus(if1.master)
  );

  function automatic logic [35:0] lut(input logic [1:0] i);
    case (i)
      2'd0:    return 36'h00012C4B;
      2'd1:    return 36'h00019064;
      2'd2:    return 36'h0001F47D;
      default: return 36'h00025896;
    endcase
  endfunction

  assign if0.start   = start;
  assign if1.start   = start;
  assign if0.allowed = allowed;
  assign if1.allowed = allowed;
  assign if0.value   = lut(if0.index);
  assign if1.value   = lut(if1.index);

`ifdef ZBT_WR_VERIFY_EN
  // ZBT model: address in cycle t, read data visible in cycle t+2
  logic [35:0] m0 [8];
  logic [35:0] m1 [8];
  logic [35:0] r0a = '0, r0b = '0, r1a = '0, r1b = '0;
  initial begin
    for (int i = 0; i < 8; i++) begin
      m0[i] = '0;
      m1[i] = '0;
    end
  end
  always @(posedge clk) begin
    if (if0.mem_we)
      m0[if0.mem_addr[2:0]] <= (corrupt && if0.mem_addr == 19'h00002) ? 36'h0 : if0.mem_write_data;
    if (if1.mem_we)
      m1[if1.mem_addr[2:0]] <= if1.mem_write_data;
    r0a <= m0[if0.mem_addr[2:0]];
    r0b <= r0a;
    r1a <= m1[if1.mem_addr[2:0]];
    r1b <= r1a;
  end
  assign if0.mem_read_data = r0b;
  assign if1.mem_read_data = r1b;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc          <= cyc + 1;
    allowed_prev <= allowed;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: pops one expected write per mem_we cycle
  always @(negedge clk) begin
    wr_t e;
    if (if0.mem_we) begin
      last_we_cyc0 = cyc;
      if (q0.size() == 0) begin
        check("unexpected_write0", 64'(if0.mem_addr), 64'h7FFFFFFF);
      end else begin
        e = q0.pop_front();
        check("wr0_addr", 64'(if0.mem_addr), 64'(e.addr));
        check("wr0_data", 64'(if0.mem_write_data), 64'(e.data));
        check("wr0_after_allowed", 64'(allowed_prev), 64'd1);
      end
    end
    if (if1.mem_we) begin
      if (q1.size() == 0) begin
        check("unexpected_write1", 64'(if1.mem_addr), 64'h7FFFFFFF);
      end else begin
        e = q1.pop_front();
        check("wr1_addr", 64'(if1.mem_addr), 64'(e.addr));
        check("wr1_data", 64'(if1.mem_write_data), 64'(e.data));
      end
    end
    if (if0.done) begin
      done_cnt0++;
      done_cyc0 = cyc;
      check("done_sync", 64'(if1.done), 64'd1);
      check("busy_at_done", 64'(if0.busy), 64'd0);
`ifdef ZBT_WR_VERIFY_EN
      check("error0_at_done", 64'(if0.error), 64'(corrupt));
      check("error1_at_done", 64'(if1.error), 64'd0);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run();
    for (int i = 0; i < 4; i++) begin
      logic [18:0] a1;
      a1 = 19'h7FFFE + 19'(i);
      q0.push_back('{addr: 19'(i), data: lut(2'(i))});
      q1.push_back('{addr: a1, data: lut(2'(i))});
    end
  endtask

  task automatic finish_run(input string nm);
    int budget;
    runs++;
    budget = 0;
    while (done_cnt0 < runs && budget < 300) begin
      tick();
      budget++;
    end
    if (done_cnt0 < runs) begin
      errors++;
      vectors++;
      $display("FAIL %s_timeout: done count %0d expected %0d", nm, done_cnt0, runs);
    end
    repeat (4) tick();
    check({nm, "_done_count"}, 64'(done_cnt0), 64'(runs));
    check({nm, "_q0_empty"}, 64'(q0.size()), 64'd0);
    check({nm, "_q1_empty"}, 64'(q1.size()), 64'd0);
    q0.delete();
    q1.delete();
  endtask

  initial begin
    int c0;
    logic pat [7];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    reset = 1'b1;
    start = 1'b1;   // start during reset must be ignored
    allowed = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("rst_we",    64'(if0.mem_we), 64'd0);
    check("rst_busy",  64'(if0.busy), 64'd0);
    check("rst_done",  64'(if0.done), 64'd0);
    check("rst_index", 64'(if0.index), 64'd0);
    check("rst_addr0", 64'(if0.mem_addr), 64'h00000);
    check("rst_addr1", 64'(if1.mem_addr), 64'h7FFFE);
    check("rst_wdata", 64'(if0.mem_write_data), 64'd0);
`ifdef ZBT_WR_VERIFY_EN
    check("rst_error", 64'(if0.error), 64'd0);
`endif
    tick();
    start = 1'b0;
    reset = 1'b0;
    tick();

    // Run 1: allowed held high, exact latency
    push_run();
    start = 1'b1;
    c0 = cyc;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
`ifndef ZBT_WR_VERIFY_EN
      check("t1_busy", 64'(if0.busy), 64'(k >= 1 && k <= 5));
      check("t1_we",   64'(if0.mem_we), 64'(k >= 2 && k <= 5));
      check("t1_done", 64'(if0.done), 64'(k == 6));
`endif
      tick();
      start = 1'b0;
    end
    finish_run("t1");

    // Run 2: allowed pattern 1,0,0,1,0,1,1 during WRITE
    push_run();
    start = 1'b1;
    c0 = cyc;
    for (int k = 1; k <= 7; k++) begin
      tick();
      start = 1'b0;
      allowed = pat[k-1];
    end
    tick();
    allowed = 1'b1;
    finish_run("t2");
`ifndef ZBT_WR_VERIFY_EN
    check("t2_last_we_cyc", 64'(last_we_cyc0 - c0), 64'd8);
    check("t2_done_cyc", 64'(done_cyc0 - c0), 64'd9);
`endif

    // Run 3: start re-pulsed at cycle 3
    push_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    finish_run("t3");

    // Run 4: reset with two writes complete, then a full run
    push_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("t4_we",      64'(if0.mem_we), 64'd0);
    check("t4_busy",    64'(if0.busy), 64'd0);
    check("t4_addr",    64'(if0.mem_addr), 64'h00000);
    check("t4_pending", 64'(q0.size()), 64'd2);
    q0.delete();
    q1.delete();
    tick();
    tick();
    check("t4_no_done", 64'(done_cnt0), 64'(runs));
    push_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    finish_run("t4");

`ifdef ZBT_WR_VERIFY_EN
    // Run 5: memory corrupts address 2 -> error at done; then clean run
    corrupt = 1'b1;
    push_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    finish_run("t5");
    check("t5_error_sticky", 64'(if0.error), 64'd1);
    corrupt = 1'b0;
    push_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    finish_run("t6");
    check("t6_error_clear", 64'(if0.error), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
